appr_mac_ctrl: RTL and testbench



---
 rtl/appr_mac_ctrl.sv | 132 +++++++++++++
 tb/tb_appr_mac_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/appr_mac_ctrl.sv
// Operand sequencer and dot-product accumulator for the 8x8 approximate multiplier.
// Issues VEC_LEN operand pairs, retires products after MUL_LAT cycles, presents the sum.
module appr_mac_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ISSUE,
    DRAIN,
    HOLD
  } state_e;

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VEC_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [MUL_LAT:0] tag_q, tag_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       ma_q, ma_d;
  logic [7:0]       mb_q, mb_d;
  logic             ov_q, ov_d;
  logic [ACC_W-1:0] sum_q, sum_d;

  logic             accept;
  logic             retire;
  logic [ACC_W:0]   add_w;

  assign in_ready  = (state_q == ISSUE) && (icnt_q < FULL);
  assign accept    = in_valid & in_ready;
  // The tag leaving the pipe marks the cycle in which mul_p is valid.
  assign retire    = tag_q[MUL_LAT];
  assign add_w     = {1'b0, acc_q} + (ACC_W + 1)'(mul_p);

  assign mul_a     = ma_q;
  assign mul_b     = mb_q;
  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    rcnt_d  = rcnt_q;
    tag_d   = tag_q << 1;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    ov_d    = ov_q;
    sum_d   = sum_q;

    tag_d[0] = accept;

    if (accept) begin
      ma_d   = in_a;
      mb_d   = in_b;
      icnt_d = icnt_q + CNT_W'(1);
      if (icnt_q == LAST) begin
        state_d = DRAIN;
      end
    end

    // Completion follows the retire count, whatever state we are in.
    if (retire) begin
      acc_d  = add_w[ACC_W-1:0];
      ovf_d  = ovf_q | add_w[ACC_W];
      rcnt_d = rcnt_q + CNT_W'(1);
      if (rcnt_q == LAST) begin
        ov_d    = 1'b1;
        sum_d   = add_w[ACC_W-1:0];
        state_d = HOLD;
      end
    end

    if (ov_q && out_ready) begin
      ov_d    = 1'b0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      icnt_d  = '0;
      rcnt_d  = '0;
      tag_d   = '0;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ISSUE;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      ov_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      ov_q    <= ov_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_appr_mac_ctrl.sv
// Scoreboard bench for appr_mac_ctrl: default instance plus a narrow
// 16-bit, 2-product, combinational-multiplier instance.
module tb_appr_mac_ctrl;

  localparam int L1 = 2;
  localparam int V1 = 8;
  localparam int W1 = 24;
  localparam int L2 = 0;
  localparam int V2 = 2;
  localparam int W2 = 16;

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          in_valid = 0;
  logic          in_ready;
  logic [7:0]    in_a = 0;
  logic [7:0]    in_b = 0;
  logic [7:0]    mul_a, mul_b;
  logic [15:0]   mul_p;
  logic          out_valid;
  logic          out_ready = 1;
  logic [W1-1:0] out_sum;
  logic          out_ovf;

  logic          in_valid2 = 0;
  logic          in_ready2;
  logic [7:0]    in_a2 = 0;
  logic [7:0]    in_b2 = 0;
  logic [7:0]    mul_a2, mul_b2;
  logic [15:0]   mul_p2;
  logic          out_valid2;
  logic          out_ready2 = 1;
  logic [W2-1:0] out_sum2;
  logic          out_ovf2;

  appr_mac_ctrl #(.MUL_LAT(L1), .VEC_LEN(V1), .ACC_W(W1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  appr_mac_ctrl #(.MUL_LAT(L2), .VEC_LEN(V2), .ACC_W(W2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .out_ovf(out_ovf2)
  );

  // Exact multiplier stubs: two-stage pipe and combinational.
  logic [15:0] p1 = 0;
  logic [15:0] p2 = 0;
  always @(posedge clk) begin
    p1 <= 16'(mul_a) * 16'(mul_b);
    p2 <= p1;
  end
  assign mul_p  = p2;
  assign mul_p2 = 16'(mul_a2) * 16'(mul_b2);

  // Reference model: plain sum of products per vector.
  logic [W1-1:0] q1_sum[$];
  logic          q1_ovf[$];
  logic [W2-1:0] q2_sum[$];
  logic          q2_ovf[$];
  longint cur1 = 0;
  int     n1 = 0;
  longint cur2 = 0;
  int     n2 = 0;

  task automatic model1(input logic [7:0] a, input logic [7:0] b);
    cur1 += longint'(a) * longint'(b);
    n1++;
    if (n1 == V1) begin
      q1_sum.push_back(W1'(cur1 % (longint'(1) << W1)));
      q1_ovf.push_back(cur1 >= (longint'(1) << W1));
      cur1 = 0;
      n1 = 0;
    end
  endtask

  task automatic model2(input logic [7:0] a, input logic [7:0] b);
    cur2 += longint'(a) * longint'(b);
    n2++;
    if (n2 == V2) begin
      q2_sum.push_back(W2'(cur2 % (longint'(1) << W2)));
      q2_ovf.push_back(cur2 >= (longint'(1) << W2));
      cur2 = 0;
      n2 = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1;
    in_a = a;
    in_b = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send1_timeout: in_ready stuck low");
      in_valid = 0;
    end else begin
      @(posedge clk);
      model1(a, b);
      #1 in_valid = 0;
    end
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid2 = 1;
    in_a2 = a;
    in_b2 = b;
    while (!in_ready2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready2) begin
      checks++;
      errors++;
      $display("FAIL send2_timeout: in_ready stuck low");
      in_valid2 = 0;
    end else begin
      @(posedge clk);
      model2(a, b);
      #1 in_valid2 = 0;
    end
  endtask

  task automatic wait_done;
    int t = 0;
    while ((q1_sum.size() != 0 || q2_sum.size() != 0 ||
            out_valid || out_valid2) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results pending",
               q1_sum.size(), q2_sum.size());
    end
  endtask

  // Monitors: compare whenever a result is handed off.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (q1_sum.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected: sum %0d with no expectation", out_sum);
      end else begin
        logic [W1-1:0] es;
        logic          eo;
        es = q1_sum.pop_front();
        eo = q1_ovf.pop_front();
        if (out_sum !== es || out_ovf !== eo) begin
          errors++;
          $display("FAIL out1: got sum=%0d ovf=%0b expected sum=%0d ovf=%0b",
                   out_sum, out_ovf, es, eo);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid2 && out_ready2) begin
      checks++;
      if (q2_sum.size() == 0) begin
        errors++;
        $display("FAIL out2_unexpected: sum %0d with no expectation", out_sum2);
      end else begin
        logic [W2-1:0] es;
        logic          eo;
        es = q2_sum.pop_front();
        eo = q2_ovf.pop_front();
        if (out_sum2 !== es || out_ovf2 !== eo) begin
          errors++;
          $display("FAIL out2: got sum=%0d ovf=%0b expected sum=%0d ovf=%0b",
                   out_sum2, out_ovf2, es, eo);
        end
      end
    end
  end

  initial begin
    int n;
    int gap;
    logic [7:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1;

    // Back-to-back ones: latency and re-arm timing.
    for (int i = 0; i < V1; i++) send1(8'd1, 8'd1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    chk("latency_edges", 64'(n), 64'(L1 + 1));
    chk("sum_ones", 64'(out_sum), 64'd8);
    n = 0;
    while (out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rearm_edges", 64'(n), 64'd1);
    chk("rearm_in_ready", 64'(in_ready), 64'd1);
    wait_done();

    // Maximum operands.
    for (int i = 0; i < V1; i++) send1(8'd255, 8'd255);
    wait_done();

    // Ramp with bubbles; operands must hold while idle.
    for (int i = 0; i < V1; i++) begin
      send1(8'(i + 1), 8'd2);
      gap = $urandom_range(1, 3);
      repeat (gap) begin
        @(negedge clk);
        chk("hold_mul_a", 64'(mul_a), 64'(i + 1));
        chk("hold_mul_b", 64'(mul_b), 64'd2);
      end
    end
    wait_done();

    // Consumer back-pressure.
    out_ready = 0;
    for (int i = 0; i < V1; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send1(ra, rb);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (q1_sum.size() != 0) begin
        chk("bp_out_sum", 64'(out_sum), 64'(q1_sum[0]));
        chk("bp_out_ovf", 64'(out_ovf), 64'(q1_ovf[0]));
      end else begin
        chk("bp_queue", 64'(q1_sum.size()), 64'd1);
      end
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release", 64'(out_valid), 64'd0);
    wait_done();

    // Asynchronous reset mid-vector.
    for (int i = 0; i < 3; i++) send1(8'd7, 8'd9);
    #1 rst = 0;
    cur1 = 0;
    n1 = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_sum", 64'(out_sum), 64'd0);
    chk("arst_out_ovf", 64'(out_ovf), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < V1; i++) send1(8'd3, 8'd4);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arst_next_sum", 64'(out_sum), 64'd96);
    wait_done();

    // Random vectors with random bubbles.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < V1; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        send1(ra, rb);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_done();

    // Narrow instance: wrap and overflow, then a clean vector.
    for (int i = 0; i < V2; i++) send2(8'd255, 8'd255);
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w16_sum", 64'(out_sum2), 64'd64514);
    chk("w16_ovf", 64'(out_ovf2), 64'd1);
    wait_done();
    for (int i = 0; i < V2; i++) send2(8'd1, 8'd1);
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w16_next_sum", 64'(out_sum2), 64'd2);
    chk("w16_next_ovf", 64'(out_ovf2), 64'd0);
    wait_done();
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < V2; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        send2(ra, rb);
      end
    end
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
